// File: rtl/mema_loader_pkg.sv
// +----------------------------------------------------------------------+
// | mema_loader_pkg : shared state encoding and sizing helper            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mema_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    FEED  = 3'd3,
    DONE  = 3'd4
  } mema_ld_state_t;

  // Counter width that stays at least one bit for single-value ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mema_row_asm.sv
// +----------------------------------------------------------------------+
// | mema_row_asm : assembles WPR stream words into one DIM-element row   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mema_row_asm
  import mema_loader_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int WORD_W  = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wr,
  input  logic [WORD_W-1:0]                data,
  output logic                             last_word,
  output logic [DIM-1:0][BITS_AB-1:0]      row
);

  localparam int EPW = WORD_W / BITS_AB;
  localparam int WPR = DIM / EPW;
  localparam int WCW = cnt_w(WPR);

  logic [WCW-1:0]                word_cnt_q, word_cnt_d;
  logic [DIM-1:0][BITS_AB-1:0]   row_q, row_d;

  assign last_word = (word_cnt_q == WCW'(WPR - 1));
  assign row       = row_q;

  always_comb begin
    word_cnt_d = word_cnt_q;
    row_d      = row_q;
    if (clr) begin
      word_cnt_d = '0;
    end else if (wr) begin
      word_cnt_d = last_word ? '0 : word_cnt_q + WCW'(1);
      // Constant-index slices keep the write a plain mux per element.
      for (int w = 0; w < WPR; w++) begin
        if (word_cnt_q == WCW'(w)) begin
          for (int k = 0; k < EPW; k++) begin
            row_d[w*EPW + k] = data[k*BITS_AB +: BITS_AB];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      row_q      <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      row_q      <= row_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mema_loader.sv
// +----------------------------------------------------------------------+
// | mema_loader : stream-to-memA row loader and feed sequencer           |
// | Optional error detection: MEMA_LOADER_ERR_EN. Revision: 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module mema_loader
  import mema_loader_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int WORD_W  = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WORD_W-1:0]                   in_data,
  input  logic                                stall,
  output logic [DIM-1:0][BITS_AB-1:0]         Ain,
  output logic [cnt_w(DIM)-1:0]               Arow,
  output logic                                WrEn,
  output logic                                en,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam int FEED_LEN = 3*DIM - 2;
  localparam int RCW      = cnt_w(DIM);
  localparam int FCW      = cnt_w(FEED_LEN);

  mema_ld_state_t   state_q, state_d;
  logic [RCW-1:0]   row_cnt_q, row_cnt_d;
  logic [FCW-1:0]   feed_cnt_q, feed_cnt_d;
  logic             accept;
  logic             last_word;
  logic             clr;

  assign in_ready = (state_q == LOAD);
  assign accept   = in_valid & in_ready;
  assign clr      = (state_q == IDLE) & start;
  assign WrEn     = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign en       = (state_q == FEED) & ~stall;
  assign Arow     = row_cnt_q;

  mema_row_asm #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .WORD_W  (WORD_W)
  ) u_row_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wr        (accept),
    .data      (in_data),
    .last_word (last_word),
    .row       (Ain)
  );

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    feed_cnt_d = feed_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_cnt_d  = '0;
          feed_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (accept && last_word) state_d = WRITE;
      end
      WRITE: begin
        if (row_cnt_q == RCW'(DIM - 1)) begin
          state_d = FEED;
        end else begin
          row_cnt_d = row_cnt_q + RCW'(1);
          state_d   = LOAD;
        end
      end
      FEED: begin
        // Only unstalled cycles advance the drain.
        if (en) begin
          if (feed_cnt_q == FCW'(FEED_LEN - 1)) state_d = DONE;
          else feed_cnt_d = feed_cnt_q + FCW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      feed_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      feed_cnt_q <= feed_cnt_d;
    end
  end

`ifdef MEMA_LOADER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (start & busy) | (in_valid & (state_q != LOAD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mema_loader.sv
// +----------------------------------------------------------------------+
// | tb_mema_loader : directed self-checking bench for mema_loader        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mema_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: defaults (WPR=1)
  logic              a_start, a_in_valid, a_in_ready, a_stall;
  logic [63:0]       a_in_data;
  logic [7:0][7:0]   a_ain;
  logic [2:0]        a_arow;
  logic              a_wren, a_en, a_busy, a_done, a_err;

  // Instance B: WORD_W=32 (WPR=2)
  logic              b_start, b_in_valid, b_in_ready, b_stall;
  logic [31:0]       b_in_data;
  logic [7:0][7:0]   b_ain;
  logic [2:0]        b_arow;
  logic              b_wren, b_en, b_busy, b_done, b_err;

  mema_loader #(.BITS_AB(8), .DIM(8), .WORD_W(64)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .stall(a_stall),
    .Ain(a_ain), .Arow(a_arow), .WrEn(a_wren), .en(a_en),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  mema_loader #(.BITS_AB(8), .DIM(8), .WORD_W(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .stall(b_stall),
    .Ain(b_ain), .Arow(b_arow), .WrEn(b_wren), .en(b_en),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Row r element c = r*8+c, element 0 in the low byte.
  function automatic logic [63:0] row_vec(input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = 8'(r*8 + c);
    return v;
  endfunction

  // Cycle 1 is the start cycle; with in_valid held high DONE lands on cycle 40.
  task automatic run_a(input bit toggle, input int stall_at, input int stall_len,
                       input int extra_start, output int done_cyc, output int wr_cnt,
                       output int en_cnt, output int en_in_stall);
    int  w;
    bit  v, r, stl;
    w = 0; done_cyc = -1; wr_cnt = 0; en_cnt = 0; en_in_stall = 0;
    a_start = 1'b1; a_in_valid = 1'b0; a_stall = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 2; cyc <= 200 && done_cyc < 0; cyc++) begin
      stl        = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      a_start    = (cyc == extra_start);
      a_stall    = stl;
      a_in_valid = (w < 8) && (!toggle || (cyc % 2 == 1));
      a_in_data  = row_vec(w);
      #1;
      if (a_wren) begin
        check("a_arow", 64'(a_arow), 64'(wr_cnt));
        check("a_row_data", a_ain, row_vec(wr_cnt));
        wr_cnt++;
      end
      if (a_en) en_cnt++;
      if (a_en && stl) en_in_stall++;
      if (a_done) done_cyc = cyc;
      v = a_in_valid; r = a_in_ready;
      @(posedge clk); #1;
      if (v && r) w++;
    end
    a_start = 1'b0; a_in_valid = 1'b0; a_stall = 1'b0;
  endtask

  initial begin
    int dc, wc, ec, es, w, bwr, bdone;
    bit v, r;
    logic [63:0] rv;

    rst_n = 1'b0;
    a_start = 0; a_in_valid = 0; a_stall = 0; a_in_data = '0;
    b_start = 0; b_in_valid = 0; b_stall = 0; b_in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wren",     64'(a_wren),     64'd0);
    check("rst_en",       64'(a_en),       64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    check("rst_busy",     64'(a_busy),     64'd0);
    check("rst_done",     64'(a_done),     64'd0);
    check("rst_err",      64'(a_err),      64'd0);
    check("rst_arow",     64'(a_arow),     64'd0);
    check("rst_ain",      a_ain,           64'd0);

    rst_n = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(a_in_ready), 64'd0);
    check("idle_busy",     64'(a_busy),     64'd0);
`ifdef MEMA_LOADER_ERR_EN
    check("idle_err", 64'(a_err), 64'd1);
`else
    check("idle_err", 64'(a_err), 64'd0);
`endif
    a_in_valid = 1'b0;
    @(posedge clk); #1;

    // Full tile, valid held high, no stall
    run_a(1'b0, 0, 0, 0, dc, wc, ec, es);
    check("base_done_cycle", 64'(dc), 64'd40);
    check("base_wren_count", 64'(wc), 64'd8);
    check("base_en_count",   64'(ec), 64'd22);
    check("base_idle_after", 64'(a_busy), 64'd0);

    // in_valid toggling during LOAD
    run_a(1'b1, 0, 0, 0, dc, wc, ec, es);
    check("tog_wren_count", 64'(wc), 64'd8);
    check("tog_en_count",   64'(ec), 64'd22);

    // Five stall cycles inside FEED (FEED spans cycles 18..39)
    run_a(1'b0, 25, 5, 0, dc, wc, ec, es);
    check("stall_done_cycle", 64'(dc), 64'd45);
    check("stall_en_count",   64'(ec), 64'd22);
    check("stall_en_gated",   64'(es), 64'd0);

    // Abort during row 4 LOAD: rows 0..3 take cycles 2..9
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      a_in_data  = row_vec((c - 2) / 2);
      a_in_valid = (c % 2 == 0);
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    #1;
    check("mid_in_ready", 64'(a_in_ready), 64'd1);
    check("mid_arow",     64'(a_arow),     64'd4);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(a_busy), 64'd0);
    check("abort_wren", 64'(a_wren), 64'd0);
    check("abort_en",   64'(a_en),   64'd0);
    check("abort_arow", 64'(a_arow), 64'd0);
    check("abort_ain",  a_ain,       64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // New tile after abort, with a stray start during FEED
    run_a(1'b0, 0, 0, 25, dc, wc, ec, es);
    check("restart_done_cycle", 64'(dc), 64'd40);
    check("restart_wren_count", 64'(wc), 64'd8);
    check("feed_start_ignored", 64'(a_busy), 64'd0);

    // Start coincident with DONE is ignored
    run_a(1'b0, 0, 0, 40, dc, wc, ec, es);
    check("done_start_done_cycle", 64'(dc), 64'd40);
    check("done_start_ignored",    64'(a_busy), 64'd0);

    // Instance B: two words per row, WrEn every third cycle from cycle 4
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    w = 0; bwr = 0; bdone = -1;
    for (int cyc = 2; cyc <= 200 && bdone < 0; cyc++) begin
      rv         = row_vec(w / 2);
      b_in_valid = (w < 16);
      b_in_data  = rv[(w % 2)*32 +: 32];
      #1;
      if (b_wren) begin
        check("b_wr_cycle", 64'(cyc), 64'(4 + 3*bwr));
        check("b_arow",     64'(b_arow), 64'(bwr));
        check("b_row_data", b_ain, row_vec(bwr));
        bwr++;
      end
      if (b_done) bdone = cyc;
      v = b_in_valid; r = b_in_ready;
      @(posedge clk); #1;
      if (v && r) w++;
    end
    b_in_valid = 1'b0;
    check("b_wren_count", 64'(bwr),   64'd8);
    check("b_done_cycle", 64'(bdone), 64'd48);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
